kw_fifo_cntl_prog: RTL and testbench
====================================

# kw_fifo_cntl_prog

Next-generation single-clock FIFO controller driving an external dual-port RAM. It adds the following over the fixed-threshold controller:
- runtime-programmable almost-empty/almost-full thresholds;
- any DEPTH, not only powers of two, with correct pointer wrap;
- protected overflow/underflow (rejected requests never move pointers);
- a synchronous clear;
- a live word count;
- a fully implemented ERR_MODE 0 that latches the first error cause.

It sits between a producer/consumer pair and a 1R1W RAM with asynchronous read.

## Interface
- DATA_WIDTH, 16: data width in bits
- DEPTH, 16: capacity in words, range [2, 2^24], any integer
- ERR_MODE, 1: 0 = sticky, first cause latched; 1 = sticky, causes accumulate; 2 = unlatched
- ADDR_WIDTH, $clog2(DEPTH): derived, do not override
- COUNT_BITS, $clog2(DEPTH+1): derived, do not override

Ports:
- clock  in  1  rising-edge clock; the block has one clock
- reset_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush, active high
- push_req / pop_req  in  1 each  push / pop request
- data_i  in  DATA_WIDTH  write data
- data_o  out  DATA_WIDTH  head-of-queue data (= ram_rd_data)
- ae_level  in  COUNT_BITS  almost-empty threshold
- af_level  in  COUNT_BITS  almost-full margin
- empty, almost_empty, half_full, almost_full, full  out  1 each  level flags
- word_count  out  COUNT_BITS  current occupancy
- error  out  1  error flag, active high
- err_cause  out  2  bit0 = overflow, bit1 = underflow
- ram_we_n  out  1  RAM write enable, active low
- ram_wr_addr / ram_rd_addr  out  ADDR_WIDTH  RAM write/read address
- ram_wr_data  out  DATA_WIDTH  = data_i
- ram_rd_data  in  DATA_WIDTH  RAM read data, combinational from ram_rd_addr

## Operation
- State:
  - wr_ptr, rd_ptr in [0, DEPTH-1]
  - count in [0, DEPTH]
  - err_q, cause_q
- Acceptance rules:
  - pop_ok = pop_req && !empty
  - push_ok = push_req && (!full || pop_req)
  - The pop_req exception when full is safe: full implies !empty, so the pop always succeeds.
- Overflow = push_req && full && !pop_req.
- Underflow = pop_req && empty. A simultaneous push is still accepted.
- Rejected requests change no pointer and no count; only the error logic sees them.
- Pointer advance: ptr+1, wrapping DEPTH-1 -> 0 (explicit compare, not natural overflow).
- count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Flags are combinational from the count register and the threshold inputs:
  - empty: count==0
  - full: count==DEPTH
  - half_full: count>=DEPTH/2
  - almost_empty: count<=ae_level
  - almost_full: count>=DEPTH-af_level, compared at COUNT_BITS+1 width
  - If af_level>DEPTH, almost_full is held 1.
- ae_level and af_level are quasi-static. Changing them takes effect combinationally; there is no hazard protection.
- ram_we_n = !push_ok. Rejected writes never reach the RAM.
- clear takes priority over push and pop. It zeroes the pointers, count, err_q and cause_q, and forces ram_we_n=1 in that cycle.
- Error modes:
  - Mode 0: the first error sets err_q and latches cause_q; later errors do not change cause_q until reset or clear.
  - Mode 1: err_q |= any error; cause_q |= causes.
  - Mode 2: error and err_cause are combinational from the current cycle's requests, with no registers.

## Timing
- Reset values: pointers 0, count 0, so empty=1, almost_empty=1, full=0, half_full=0, word_count=0; error=0, err_cause=0, ram_we_n=!push_ok (reads 1 while push_req is low).
- Reset asserted mid-operation clears all state immediately; RAM contents are don't-care afterwards.
- Write: RAM captures data_i at the clock edge where ram_we_n=0. The word is readable on data_o one cycle later if it became the head.
- Read: data_o shows the head word combinationally. pop_ok advances rd_ptr at the edge, and the next word appears after that edge.
- Flags and word_count update one cycle after the accepted operation (edge-registered count).
- Errors in modes 0 and 1 appear the cycle after the offending request; in mode 2 they appear in the same cycle.

## Structure
- Package kw_fifo_pkg holds:
  - typedef enum err_mode_e {ERR_STICKY_FIRST, ERR_STICKY_ACC, ERR_UNLATCHED}
  - the 2-bit err_cause_t with OVF/UDF bit constants
  - the elaboration-time checks on DEPTH
- Sub-module kw_fifo_wrap_ptr (parameters DEPTH, ADDR_WIDTH; ports clock, reset_n, clear, inc, ptr) is instantiated twice, for wr_ptr and rd_ptr.

## Test plan
- DEPTH=5, ae_level=1, af_level=1:
  - Push 5 words A..E -> word_count steps 1..5. almost_full at count 4, full at count 5, ram_wr_addr sequence 0,1,2,3,4.
  - Pop all 5, then push once more -> ram_wr_addr wraps to 0, data_o returns A..E in order.
- Full FIFO:
  - Push only -> ram_we_n=1, count stays 5.
  - Mode 1 -> error=1 next cycle, err_cause=2'b01.
  - Push+pop together -> accepted, count stays 5, no error.
- Empty FIFO, push+pop in the same cycle -> push accepted, count=1, pop rejected. In mode 0: error=1, err_cause=2'b10.
- Mode 0: overflow, then underflow -> err_cause stays 2'b01. clear -> error=0, empty=1, pointers 0.
- Mode 2: a single pop on empty -> error=1 only during that cycle, 0 the next.
- Change ae_level from 1 to 3 with count=2 -> almost_empty rises in the same cycle. Assert reset_n low mid-burst -> all outputs at reset values with no clock edge.

Source files
------------

// File: rtl/kw_fifo_pkg.sv
// kw_fifo_pkg: shared types, cause encodings and elaboration checks for the programmable FIFO controller
package kw_fifo_pkg;
  typedef enum logic [1:0] {ERR_STICKY_FIRST, ERR_STICKY_ACC, ERR_UNLATCHED} err_mode_e;
  typedef logic [1:0] err_cause_t;
  localparam err_cause_t CAUSE_OVF = 2'b01;
  localparam err_cause_t CAUSE_UDF = 2'b10;
  function automatic bit depth_ok(input longint depth);
    return depth >= 2 && depth <= (longint'(1) << 24);
  endfunction
  function automatic bit err_mode_ok(input int mode);
    return mode >= 0 && mode <= 2;
  endfunction
endpackage

// File: rtl/kw_fifo_cntl_prog_if.sv
// kw_fifo_cntl_prog_if: producer/consumer, threshold, status and RAM-side signals of the FIFO controller
interface kw_fifo_cntl_prog_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int COUNT_BITS = 5
);
  logic                  push_req;
  logic                  pop_req;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [COUNT_BITS-1:0] ae_level;
  logic [COUNT_BITS-1:0] af_level;
  logic                  empty;
  logic                  almost_empty;
  logic                  half_full;
  logic                  almost_full;
  logic                  full;
  logic [COUNT_BITS-1:0] word_count;
  logic                  error;
  logic [1:0]            err_cause;
  logic                  ram_we_n;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  modport slave (
    input  push_req, pop_req, data_i, ae_level, af_level, ram_rd_data,
    output data_o, empty, almost_empty, half_full, almost_full, full, word_count,
           error, err_cause, ram_we_n, ram_wr_addr, ram_rd_addr, ram_wr_data
  );
  modport master (
    output push_req, pop_req, data_i, ae_level, af_level, ram_rd_data,
    input  data_o, empty, almost_empty, half_full, almost_full, full, word_count,
           error, err_cause, ram_we_n, ram_wr_addr, ram_rd_addr, ram_wr_data
  );
endinterface

// File: rtl/kw_fifo_wrap_ptr.sv
// kw_fifo_wrap_ptr: RAM address pointer that wraps at DEPTH-1 for any (non power-of-two) depth
module kw_fifo_wrap_ptr #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clear ? '0 : !inc ? ptr_q : (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/kw_fifo_cntl_prog.sv
// kw_fifo_cntl_prog: single-clock FIFO controller for an external 1R1W async-read RAM,
// with programmable thresholds, protected over/underflow, synchronous clear and selectable error latching
module kw_fifo_cntl_prog
  import kw_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ERR_MODE   = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int COUNT_BITS = $clog2(DEPTH + 1)
) (
  input logic                clock,
  input logic                reset_n,
  input logic                clear,
  kw_fifo_cntl_prog_if.slave bus
);
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("kw_fifo_cntl_prog: DEPTH must lie in [2, 2^24]");
  end
  if (!err_mode_ok(ERR_MODE)) begin : g_bad_mode
    $error("kw_fifo_cntl_prog: ERR_MODE must be 0, 1 or 2");
  end
  localparam err_mode_e             MODE     = err_mode_e'(ERR_MODE);
  localparam logic [COUNT_BITS-1:0] FULL_CNT = COUNT_BITS'(DEPTH);
  localparam logic [COUNT_BITS-1:0] HALF_CNT = COUNT_BITS'(DEPTH / 2);
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  err_q, err_d;
  err_cause_t            cause_q, cause_d, cause_now;
  logic                  empty, full, push_ok, pop_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  assign empty   = count_q == '0;
  assign full    = count_q == FULL_CNT;
  // full implies non-empty, so a push alongside a pop on a full queue is always safe
  assign push_ok = !clear && bus.push_req && (!full || bus.pop_req);
  assign pop_ok  = !clear && bus.pop_req && !empty;
  assign cause_now = clear ? '0 : ({1'b0, bus.push_req && full && !bus.pop_req} & CAUSE_OVF)
                                | ({bus.pop_req && empty, 1'b0} & CAUSE_UDF);
  always_comb count_d = clear ? '0
                      : (push_ok && !pop_ok) ? count_q + 1'b1
                      : (pop_ok && !push_ok) ? count_q - 1'b1
                      : count_q;
  always_comb begin
    err_d   = err_q;
    cause_d = cause_q;
    if (clear) begin
      err_d   = 1'b0;
      cause_d = '0;
    end else if (MODE == ERR_STICKY_ACC) begin
      err_d   = err_q | (|cause_now);
      cause_d = cause_q | cause_now;
    end else if (MODE == ERR_STICKY_FIRST && !err_q && |cause_now) begin
      err_d   = 1'b1;
      cause_d = cause_now;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  kw_fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clock(clock), .reset_n(reset_n), .clear(clear), .inc(push_ok), .ptr(wr_ptr)
  );
  kw_fifo_wrap_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clock(clock), .reset_n(reset_n), .clear(clear), .inc(pop_ok), .ptr(rd_ptr)
  );
  assign head             = bus.ram_rd_data;
  assign bus.data_o       = head;
  assign bus.ram_wr_data  = bus.data_i;
  assign bus.ram_we_n     = !push_ok;
  assign bus.ram_wr_addr  = wr_ptr;
  assign bus.ram_rd_addr  = rd_ptr;
  assign bus.word_count   = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.half_full    = count_q >= HALF_CNT;
  assign bus.almost_empty = count_q <= bus.ae_level;
  // extra bit keeps DEPTH - af_level from wrapping; oversized margins pin the flag high
  assign bus.almost_full  = (bus.af_level > FULL_CNT)
                         || ({1'b0, count_q} >= ({1'b0, FULL_CNT} - {1'b0, bus.af_level}));
  assign bus.error        = (MODE == ERR_UNLATCHED) ? |cause_now : err_q;
  assign bus.err_cause    = (MODE == ERR_UNLATCHED) ? cause_now : cause_q;
endmodule

// File: tb/tb_kw_fifo_cntl_prog.sv
// tb_kw_fifo_cntl_prog: three DEPTH=5 controllers (error modes 0/1/2) share one stimulus stream;
// popped head words are scored against a queue of accepted pushes
module tb_kw_fifo_cntl_prog;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic push = 1'b0, pop = 1'b0;
  logic [15:0] din = '0;
  logic [2:0] ae = 3'd1, af = 3'd1;
  int n_chk = 0, n_pass = 0;
  int mc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;
  logic [15:0] mem0 [8], mem1 [8], mem2 [8];

  always #5 clock = ~clock;

  kw_fifo_cntl_prog_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .COUNT_BITS(3)) if0 ();
  kw_fifo_cntl_prog_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .COUNT_BITS(3)) if1 ();
  kw_fifo_cntl_prog_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .COUNT_BITS(3)) if2 ();

  kw_fifo_cntl_prog #(.DATA_WIDTH(16), .DEPTH(5), .ERR_MODE(0)) dut0 (.clock(clock), .reset_n(reset_n), .clear(clear), .bus(if0));
  kw_fifo_cntl_prog #(.DATA_WIDTH(16), .DEPTH(5), .ERR_MODE(1)) dut1 (.clock(clock), .reset_n(reset_n), .clear(clear), .bus(if1));
  kw_fifo_cntl_prog #(.DATA_WIDTH(16), .DEPTH(5), .ERR_MODE(2)) dut2 (.clock(clock), .reset_n(reset_n), .clear(clear), .bus(if2));

  assign if0.push_req = push;  assign if1.push_req = push;  assign if2.push_req = push;
  assign if0.pop_req  = pop;   assign if1.pop_req  = pop;   assign if2.pop_req  = pop;
  assign if0.data_i   = din;   assign if1.data_i   = din;   assign if2.data_i   = din;
  assign if0.ae_level = ae;    assign if1.ae_level = ae;    assign if2.ae_level = ae;
  assign if0.af_level = af;    assign if1.af_level = af;    assign if2.af_level = af;
  assign if0.ram_rd_data = mem0[if0.ram_rd_addr];
  assign if1.ram_rd_data = mem1[if1.ram_rd_addr];
  assign if2.ram_rd_data = mem2[if2.ram_rd_addr];

  always @(posedge clock) begin
    if (!if0.ram_we_n) mem0[if0.ram_wr_addr] <= if0.ram_wr_data;
    if (!if1.ram_we_n) mem1[if1.ram_wr_addr] <= if1.ram_wr_data;
    if (!if2.ram_we_n) mem2[if2.ram_wr_addr] <= if2.ram_wr_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // one cycle of stimulus; the bench model decides acceptance from its own occupancy count
  task automatic drive(input logic p, input logic q, input logic [15:0] d, input logic c = 1'b0);
    bit pa, qa;
    @(negedge clock);
    push = p; pop = q; din = d; clear = c;
    pa = p && (mc < 5 || q);
    qa = q && mc > 0;
    if (c) begin
      exp_q.delete();
      mc = 0;
    end else begin
      if (pa) exp_q.push_back(d);
      mc = mc + int'(pa) - int'(qa);
    end
  endtask

  // monitor: whenever a DUT accepts a pop, its head word must match the scoreboard front
  always begin
    @(negedge clock);
    #3;
    if (reset_n && !clear && if0.pop_req && !if0.empty) begin
      if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
      else begin
        sb_exp = exp_q.pop_front();
        chk("sb_data0", if0.data_o, sb_exp);
        chk("sb_data1", if1.data_o, sb_exp);
        chk("sb_data2", if2.data_o, sb_exp);
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wc"}, if0.word_count, 0);
    chk({tag, "_empty"}, if0.empty, 1);
    chk({tag, "_ae"}, if0.almost_empty, 1);
    chk({tag, "_full"}, if0.full, 0);
    chk({tag, "_hf"}, if0.half_full, 0);
    chk({tag, "_af"}, if0.almost_full, 0);
    chk({tag, "_err"}, {if0.error, if1.error, if2.error}, 0);
    chk({tag, "_cause"}, {if0.err_cause, if1.err_cause, if2.err_cause}, 0);
    chk({tag, "_we_n"}, if0.ram_we_n, 1);
    chk({tag, "_ptrs"}, {if0.ram_wr_addr, if0.ram_rd_addr}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk_reset_state("rst");
    reset_n = 1'b1;

    // fill A..E: addresses 0..4, count steps 0..4 before each edge
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 16'h00A0 + 16'(i));
      #1;
      chk("fill_wr_addr", if0.ram_wr_addr, i);
      chk("fill_we_n", if0.ram_we_n, 0);
      chk("fill_wc", if0.word_count, i);
      chk("fill_af", if0.almost_full, i >= 4);
      chk("fill_full", if0.full, 0);
    end
    drive(0, 0, 0);
    #1;
    chk("full_wc", if0.word_count, 5);
    chk("full_flags", {if0.full, if0.almost_full, if0.half_full, if0.empty}, 4'b1110);

    // overflow: rejected write, mode 2 flags it at once
    drive(1, 0, 16'h0BAD);
    #1;
    chk("ovf_we_n", if0.ram_we_n, 1);
    chk("ovf_m2_now", {if2.error, if2.err_cause}, 3'b101);
    chk("ovf_m01_not_yet", {if0.error, if1.error}, 2'b00);
    drive(1, 1, 16'h00F0);
    #1;
    chk("ovf_wc", if0.word_count, 5);
    chk("ovf_m0", {if0.error, if0.err_cause}, 3'b101);
    chk("ovf_m1", {if1.error, if1.err_cause}, 3'b101);
    chk("pp_full_we_n", if0.ram_we_n, 0);
    chk("pp_full_wrap", if0.ram_wr_addr, 0);
    chk("pp_full_m2", if2.error, 0);
    drive(0, 0, 0);
    #1;
    chk("pp_full_wc", if0.word_count, 5);

    // drain B,C,D,E,F0 with rd pointer wrapping
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0);
      #1;
      chk("drain_wc", if0.word_count, 5 - i);
    end
    drive(0, 0, 0);
    #1;
    chk("drained", {if0.empty, if0.almost_empty, if0.word_count}, {2'b11, 3'd0});

    // empty push+pop: push kept, pop rejected as underflow
    drive(1, 1, 16'h0111);
    #1;
    chk("pp_empty_we_n", if0.ram_we_n, 0);
    chk("udf_m2_now", {if2.error, if2.err_cause}, 3'b110);
    drive(0, 0, 0);
    #1;
    chk("pp_empty_wc", if0.word_count, 1);
    chk("udf_m0_first_kept", {if0.error, if0.err_cause}, 3'b101);
    chk("udf_m1_acc", {if1.error, if1.err_cause}, 3'b111);

    drive(1, 0, 16'h0DEA, 1);
    #1;
    chk("clear_we_n", if0.ram_we_n, 1);
    drive(0, 0, 0);
    #1;
    chk_reset_state("clr");

    drive(1, 1, 16'h0222);
    drive(0, 0, 0);
    #1;
    chk("udf_m0_after_clr", {if0.error, if0.err_cause}, 3'b110);
    chk("udf_m1_after_clr", {if1.error, if1.err_cause}, 3'b110);
    chk("udf_wc", if0.word_count, 1);
    drive(0, 1, 0);
    drive(0, 1, 0);
    #1;
    chk("m2_pulse_on", {if2.error, if2.err_cause}, 3'b110);
    drive(0, 0, 0);
    #1;
    chk("m2_pulse_off", {if2.error, if2.err_cause}, 3'b000);

    // thresholds take effect without a clock edge
    drive(1, 0, 16'h0333);
    drive(1, 0, 16'h0444);
    drive(0, 0, 0);
    #1;
    chk("thr_wc", if0.word_count, 2);
    chk("thr_ae_lo", if0.almost_empty, 0);
    chk("thr_hf", if0.half_full, 1);
    ae = 3'd3;
    #1;
    chk("thr_ae_hi", if0.almost_empty, 1);
    af = 3'd6;
    #1;
    chk("thr_af_pinned", if0.almost_full, 1);
    af = 3'd1;
    #1;
    chk("thr_af_back", if0.almost_full, 0);

    // async reset mid-burst, before any edge of this cycle
    drive(1, 0, 16'h0555);
    #2;
    reset_n = 1'b0;
    push = 1'b0;
    exp_q.delete();
    mc = 0;
    #1;
    chk_reset_state("async");
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 0, 16'h0666);
    drive(0, 1, 0);
    drive(0, 0, 0);
    #1;
    chk("post_rst_wc", if0.word_count, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
